// File: rtl/instruction_cache.sv
// instruction_cache
//   Direct-mapped, read-only instruction cache between the fetch stage and the
//   instruction port of main memory. Hits are answered combinationally in the
//   request cycle. A miss stalls fetch while the line is refilled from memory,
//   one word per cycle. Memory reads are combinational.
//
// Ports
//   clk, rst       : clock; asynchronous active-high reset
//   cpu_request    : fetch stage wants the instruction at cpu_address
//   cpu_address    : fetch byte address (bits [1:0] ignored)
//   cpu_read_data  : instruction word, valid when cpu_request=1 and cpu_stall=0
//   cpu_stall      : fetch must hold its request
//   invalidate     : clears every valid bit (fence.i); aborts a refill
//   mem_address    : word address presented to main memory during refill
//   mem_read_data  : memory data for mem_address, same cycle
module instruction_cache #(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_request,
  input  logic [31:0] cpu_address,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  input  logic        invalidate,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_read_data
);

  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int WORD_BITS   = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_BITS = WORD_BITS + 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                 state_q;
  logic [WORD_BITS-1:0]   refillCount_q;
  logic [31:0]            refillBase_q;
  logic [NUM_LINES-1:0]   valid_q;

  logic [TAG_BITS-1:0]    tagArray  [NUM_LINES];
  logic [31:0]            dataArray [NUM_LINES*WORDS_PER_LINE];

  logic [TAG_BITS-1:0]    reqTag;
  logic [INDEX_BITS-1:0]  reqIndex;
  logic [WORD_BITS-1:0]   reqWord;
  logic [INDEX_BITS-1:0]  baseIndex;
  logic [TAG_BITS-1:0]    baseTag;
  logic                   hit;
  logic                   lastWord;
  logic [1:0]             unusedAddrBits;

  assign reqTag         = cpu_address[31 -: TAG_BITS];
  assign reqIndex       = cpu_address[OFFSET_BITS +: INDEX_BITS];
  assign reqWord        = cpu_address[2 +: WORD_BITS];
  assign baseIndex      = refillBase_q[OFFSET_BITS +: INDEX_BITS];
  assign baseTag        = refillBase_q[31 -: TAG_BITS];
  assign unusedAddrBits = cpu_address[1:0];

  // Lookup only counts in IDLE; during a refill the fetch stage is stalled.
  assign hit = (state_q == IDLE) & cpu_request & valid_q[reqIndex] &
               (tagArray[reqIndex] == reqTag);

  assign lastWord = (refillCount_q == WORD_BITS'(WORDS_PER_LINE - 1));

  // Outputs are combinational so a hit is served in the same cycle and memory
  // sees the refill address in the cycle its data is captured.
  always_comb begin
    cpu_stall     = 1'b0;
    cpu_read_data = 32'd0;
    mem_address   = 32'd0;
    if (state_q == REFILL) begin
      cpu_stall   = 1'b1;
      mem_address = refillBase_q + (32'(refillCount_q) << 2);
    end else begin
      cpu_stall = cpu_request & ~hit;
      if (hit) begin
        cpu_read_data = dataArray[{reqIndex, reqWord}];
      end
    end
  end

  // Control FSM and valid bits. Invalidate wins over starting a refill and
  // aborts one in progress. The line's valid bit drops when its refill starts
  // so a half-written line can never hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      refillCount_q <= '0;
      refillBase_q  <= '0;
      valid_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (invalidate) begin
            valid_q <= '0;
          end else if (cpu_request && !hit) begin
            refillBase_q       <= {cpu_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            refillCount_q      <= '0;
            valid_q[reqIndex]  <= 1'b0;
            state_q            <= REFILL;
          end
        end
        REFILL: begin
          if (invalidate) begin
            valid_q       <= '0;
            refillCount_q <= '0;
            state_q       <= IDLE;
          end else begin
            refillCount_q <= refillCount_q + 1'b1;
            if (lastWord) begin
              valid_q[baseIndex] <= 1'b1;
              refillCount_q      <= '0;
              state_q            <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; only the valid bits decide a hit.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && !invalidate) begin
      dataArray[{baseIndex, refillCount_q}] <= mem_read_data;
      if (lastWord) begin
        tagArray[baseIndex] <= baseTag;
      end
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache
//   Drives instruction_cache with the directed scenarios followed by random
//   fetch traffic. A line-level cache model predicts each cycle's outputs into
//   a queue; an independent monitor pops and compares on every falling edge.
module tb_instruction_cache;

  localparam int NUM_LINES = 64;
  localparam int WPL       = 4;
  localparam int LINE_BYTES = 4 * WPL;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_request = 1'b0;
  logic [31:0] cpu_address = 32'd0;
  logic        invalidate = 1'b0;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;

  typedef struct packed {
    logic        stall;
    logic [31:0] data;
    logic [31:0] maddr;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Line-level reference state
  bit          modelValid [NUM_LINES];
  int unsigned modelTag   [NUM_LINES];
  bit          refilling = 0;
  int unsigned refillBase = 0;
  int unsigned wordsFetched = 0;

  instruction_cache #(.NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WPL)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_request   (cpu_request),
    .cpu_address   (cpu_address),
    .cpu_read_data (cpu_read_data),
    .cpu_stall     (cpu_stall),
    .invalidate    (invalidate),
    .mem_address   (mem_address),
    .mem_read_data (mem_read_data)
  );

  always #5 clk = ~clk;

  // Fixed memory contents: the known words at 0x100 line, a hash elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    case (w)
      32'h100: return 32'h11111111;
      32'h104: return 32'h22222222;
      32'h108: return 32'h33333333;
      32'h10C: return 32'h44444444;
      default: return (w * 32'h9E3779B1) ^ 32'hA5A50000 ^ (w >> 3);
    endcase
  endfunction

  assign mem_read_data = memWord(mem_address);

  function automatic void clearAll();
    for (int i = 0; i < NUM_LINES; i++) modelValid[i] = 0;
  endfunction

  // Applies one cycle of inputs, predicts that cycle's outputs, then advances
  // the model to the state expected after the next rising edge.
  task automatic applyStimulus(input bit req, input logic [31:0] addr,
                               input bit inv, input bit rstv);
    exp_t        e;
    int unsigned idx;
    int unsigned tg;
    bit          hit;
    @(posedge clk);
    #1;
    cpu_request = req;
    cpu_address = addr;
    invalidate  = inv;
    rst         = rstv;
    idx = (addr / LINE_BYTES) % NUM_LINES;
    tg  = addr / (LINE_BYTES * NUM_LINES);
    e   = '0;
    if (rstv) begin
      clearAll();
      refilling = 0;
      e.stall = req;
    end else if (refilling) begin
      e.stall = 1'b1;
      e.maddr = refillBase + 4 * wordsFetched;
      if (inv) begin
        clearAll();
        refilling = 0;
      end else begin
        wordsFetched++;
        if (wordsFetched == WPL) begin
          modelValid[(refillBase / LINE_BYTES) % NUM_LINES] = 1;
          modelTag[(refillBase / LINE_BYTES) % NUM_LINES] = refillBase / (LINE_BYTES * NUM_LINES);
          refilling = 0;
        end
      end
    end else begin
      hit = req && modelValid[idx] && (modelTag[idx] == tg);
      e.stall = req && !hit;
      e.data  = hit ? memWord(addr) : 32'd0;
      if (inv) begin
        clearAll();
      end else if (req && !hit) begin
        refilling    = 1;
        refillBase   = addr - (addr % LINE_BYTES);
        wordsFetched = 0;
        modelValid[idx] = 0;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic holdRequest(input logic [31:0] addr, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, addr, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (cpu_stall !== e.stall) begin
      errors++;
      $display("[TB] FAIL stall t=%0t got=%0b want=%0b", $time, cpu_stall, e.stall);
    end
    checks++;
    if (cpu_read_data !== e.data) begin
      errors++;
      $display("[TB] FAIL read_data t=%0t got=%08h want=%08h", $time, cpu_read_data, e.data);
    end
    checks++;
    if (mem_address !== e.maddr) begin
      errors++;
      $display("[TB] FAIL mem_address t=%0t got=%08h want=%08h", $time, mem_address, e.maddr);
    end
  endtask

  // Monitor: compares on each falling edge, well away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int guard;
    clearAll();
    $display("[TB] start");

    // Reset, then the 0x108 miss: five stall cycles then the hit
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    holdRequest(32'h108, 6);

    // Back-to-back hits in the same line
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h10C, 1'b0, 1'b0);

    // Conflict eviction and re-fetch
    holdRequest(32'h500, 6);
    holdRequest(32'h100, 6);

    // Invalidate pulse then a full refill
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    holdRequest(32'h100, 6);

    // Invalidate in the second refill cycle of 0x200
    holdRequest(32'h200, 2);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    holdRequest(32'h200, 6);

    // Reset in the third refill cycle of 0x300
    holdRequest(32'h300, 3);
    applyStimulus(1'b0, 32'h300, 1'b0, 1'b1);
    holdRequest(32'h300, 6);

    // Random traffic over a small address pool to mix hits, misses, conflicts
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      a = $urandom_range(0, 3) * (LINE_BYTES * NUM_LINES) +
          $urandom_range(0, 3) * LINE_BYTES +
          $urandom_range(0, WPL - 1) * 4 + $urandom_range(0, 3);
      applyStimulus(($urandom_range(0, 9) < 8), a,
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain got=%0d pending want=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
